// File: rtl/fb_port_arbiter_if.sv
// Frame-buffer port bundle: display read request/response, raytracer write stream,
// the single memory port, and status.
interface fb_port_arbiter_if #(
  parameter int unsigned ADDR_W     = 19,
  parameter int unsigned DATA_W     = 4,
  parameter int unsigned FIFO_DEPTH = 4
);
  logic                          rd_req;
  logic [9:0]                    rd_x;
  logic [9:0]                    rd_y;
  logic [DATA_W-1:0]             rd_data;
  logic                          rd_valid;
  logic                          wr_valid;
  logic [9:0]                    wr_x;
  logic [8:0]                    wr_y;
  logic [DATA_W-1:0]             wr_data;
  logic                          wr_ready;
  logic [ADDR_W-1:0]             mem_addr;
  logic [DATA_W-1:0]             mem_wdata;
  logic                          mem_we;
  logic [DATA_W-1:0]             mem_rdata;
  logic [$clog2(FIFO_DEPTH):0]   fifo_level;
  logic                          frame_done;
  logic                          coord_err;

  modport master (
    output rd_req, rd_x, rd_y, wr_valid, wr_x, wr_y, wr_data, mem_rdata,
    input  rd_data, rd_valid, wr_ready, mem_addr, mem_wdata, mem_we, fifo_level,
           frame_done, coord_err
  );

  modport slave (
    input  rd_req, rd_x, rd_y, wr_valid, wr_x, wr_y, wr_data, mem_rdata,
    output rd_data, rd_valid, wr_ready, mem_addr, mem_wdata, mem_we, fifo_level,
           frame_done, coord_err
  );
endinterface

// File: rtl/fb_port_arbiter.sv
// Time-slot arbiter for the single-port frame buffer: phase 0 serves display reads,
// the remaining phases drain a small FIFO of raytracer pixel writes.
module fb_port_arbiter #(
  parameter int unsigned H_RES       = 640,
  parameter int unsigned V_RES       = 480,
  parameter int unsigned ADDR_W      = 19,
  parameter int unsigned DATA_W      = 4,
  parameter int unsigned SLOT_CYCLES = 4,
  parameter int unsigned RD_LAT      = 1,
  parameter int unsigned FIFO_DEPTH  = 4
) (
  input logic              CLK,
  input logic              RESET,
  fb_port_arbiter_if.slave bus
);
  localparam int unsigned PhW  = (SLOT_CYCLES > 2) ? $clog2(SLOT_CYCLES) : 1;
  localparam int unsigned IdxW = $clog2(FIFO_DEPTH);
  localparam int unsigned LvlW = IdxW + 1;

  logic [PhW-1:0]        phase_q;
  logic                  rd_pend_q;
  logic [9:0]            rd_x_q;
  logic [9:0]            rd_y_q;
  logic [RD_LAT-1:0]     lat_v_q;
  logic [RD_LAT-1:0]     lat_oob_q;
  logic [DATA_W-1:0]     rd_data_q;
  logic                  rd_valid_q;
  logic [ADDR_W-1:0]     fifo_addr_q [FIFO_DEPTH];
  logic [DATA_W-1:0]     fifo_data_q [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] fifo_last_q;
  logic [LvlW-1:0]       wptr_q;
  logic [LvlW-1:0]       rptr_q;
  logic                  frame_done_q;
  logic                  coord_err_q;

  logic [LvlW-1:0]       level;
  logic [IdxW-1:0]       widx;
  logic [IdxW-1:0]       ridx;
  logic                  rd_issue;
  logic                  rd_oob;
  logic                  wr_oob;
  logic                  wr_last;
  logic                  wr_ready;
  logic                  wr_fire;
  logic                  push;
  logic                  pop;
  logic [ADDR_W-1:0]     rd_addr;
  logic [ADDR_W-1:0]     wr_addr;

  assign level    = wptr_q - rptr_q;
  assign widx     = wptr_q[IdxW-1:0];
  assign ridx     = rptr_q[IdxW-1:0];
  assign rd_oob   = (32'(rd_x_q) >= H_RES) || (32'(rd_y_q) >= V_RES);
  assign rd_issue = (phase_q == '0) && rd_pend_q;
  assign rd_addr  = ADDR_W'(rd_x_q) + ADDR_W'(H_RES) * ADDR_W'(rd_y_q);
  assign wr_oob   = (32'(bus.wr_x) >= H_RES) || (32'(bus.wr_y) >= V_RES);
  assign wr_last  = (32'(bus.wr_x) == H_RES - 1) && (32'(bus.wr_y) == V_RES - 1);
  assign wr_addr  = ADDR_W'(bus.wr_x) + ADDR_W'(H_RES) * ADDR_W'(bus.wr_y);
  // Readiness looks at current occupancy only; a same-cycle pop does not free a slot.
  assign wr_ready = level < LvlW'(FIFO_DEPTH);
  assign wr_fire  = bus.wr_valid && wr_ready;
  assign push     = wr_fire && !wr_oob;
  assign pop      = (phase_q != '0) && (level != '0);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      phase_q      <= '0;
      rd_pend_q    <= 1'b0;
      rd_x_q       <= '0;
      rd_y_q       <= '0;
      lat_v_q      <= '0;
      lat_oob_q    <= '0;
      rd_data_q    <= '0;
      rd_valid_q   <= 1'b0;
      wptr_q       <= '0;
      rptr_q       <= '0;
      frame_done_q <= 1'b0;
      coord_err_q  <= 1'b0;
    end else begin
      phase_q <= (phase_q == PhW'(SLOT_CYCLES - 1)) ? '0 : phase_q + PhW'(1);
      // A new request always wins over clearing, so it survives a same-cycle issue.
      if (bus.rd_req) begin
        rd_pend_q <= 1'b1;
        rd_x_q    <= bus.rd_x;
        rd_y_q    <= bus.rd_y;
      end else if (rd_issue) begin
        rd_pend_q <= 1'b0;
      end
      lat_v_q[0]   <= rd_issue;
      lat_oob_q[0] <= rd_oob;
      for (int unsigned i = 1; i < RD_LAT; i++) begin
        lat_v_q[i]   <= lat_v_q[i-1];
        lat_oob_q[i] <= lat_oob_q[i-1];
      end
      rd_valid_q <= lat_v_q[RD_LAT-1];
      if (lat_v_q[RD_LAT-1]) begin
        rd_data_q <= lat_oob_q[RD_LAT-1] ? '0 : bus.mem_rdata;
      end
      if (push) wptr_q <= wptr_q + LvlW'(1);
      if (pop) rptr_q <= rptr_q + LvlW'(1);
      frame_done_q <= pop && fifo_last_q[ridx];
      if (wr_fire && wr_oob) coord_err_q <= 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (push) begin
      fifo_addr_q[widx] <= wr_addr;
      fifo_data_q[widx] <= bus.wr_data;
      fifo_last_q[widx] <= wr_last;
    end
  end

  always_comb begin
    bus.mem_we   = 1'b0;
    bus.mem_addr = '0;
    if (!RESET) begin
      if (rd_issue) begin
        if (!rd_oob) bus.mem_addr = rd_addr;
      end else if (pop) begin
        bus.mem_we   = 1'b1;
        bus.mem_addr = fifo_addr_q[ridx];
      end
    end
  end

  assign bus.mem_wdata  = fifo_data_q[ridx];
  assign bus.rd_data    = rd_data_q;
  assign bus.rd_valid   = rd_valid_q;
  assign bus.wr_ready   = wr_ready;
  assign bus.fifo_level = level;
  assign bus.frame_done = frame_done_q;
  assign bus.coord_err  = coord_err_q;
endmodule

// File: tb/tb_fb_port_arbiter.sv
// Scenario bench for fb_port_arbiter with a read-first memory model and queue scoreboards
// for committed writes and returned reads.
module tb_fb_port_arbiter;
  localparam int RD_LAT = 1;

  typedef struct {
    logic [18:0] addr;
    logic [3:0]  data;
    bit          last;
  } wr_t;

  logic       CLK = 1'b0;
  logic       RESET;
  logic [1:0] ph;
  logic [3:0] mem [0:(1<<19)-1];

  wr_t        wr_exp [$];
  logic [3:0] rd_exp [$];
  bit         coord_exp;
  bit         fd_q;
  int         total;
  int         bad;

  fb_port_arbiter_if bus ();

  fb_port_arbiter dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) begin
    if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
    bus.mem_rdata <= mem[bus.mem_addr];
  end

  always @(posedge CLK) begin
    if (RESET) ph <= 2'd0;
    else       ph <= ph + 2'd1;
  end

  // Scoreboard monitor, sampled mid-cycle.
  always @(negedge CLK) begin
    wr_t e;
    if (RESET) begin
      total++;
      if (bus.mem_we !== 1'b0 || bus.mem_addr !== 19'd0) begin
        bad++;
        $display("FAIL reset_mem_gate: we=%0b addr=%0d want we=0 addr=0", bus.mem_we,
                 bus.mem_addr);
      end
      wr_exp.delete();
      rd_exp.delete();
      coord_exp = 1'b0;
      fd_q      = 1'b0;
    end else begin
      total++;
      if (bus.fifo_level !== 3'(wr_exp.size())) begin
        bad++;
        $display("FAIL fifo_level: got %0d want %0d", bus.fifo_level, wr_exp.size());
      end
      total++;
      if (bus.wr_ready !== (wr_exp.size() < 4)) begin
        bad++;
        $display("FAIL wr_ready: got %0b want %0b", bus.wr_ready, wr_exp.size() < 4);
      end
      total++;
      if (bus.coord_err !== coord_exp) begin
        bad++;
        $display("FAIL coord_err: got %0b want %0b", bus.coord_err, coord_exp);
      end
      total++;
      if (bus.frame_done !== fd_q) begin
        bad++;
        $display("FAIL frame_done: got %0b want %0b", bus.frame_done, fd_q);
      end
      fd_q = 1'b0;
      if (bus.mem_we === 1'b1) begin
        total++;
        if (ph == 2'd0) begin
          bad++;
          $display("FAIL write_in_read_slot: phase got %0d want 1..3", ph);
        end
        total++;
        if (wr_exp.size() == 0) begin
          bad++;
          $display("FAIL unexpected_write: addr got %0d want no write", bus.mem_addr);
        end else begin
          e = wr_exp.pop_front();
          if (bus.mem_addr !== e.addr || bus.mem_wdata !== e.data) begin
            bad++;
            $display("FAIL write_commit: got addr %0d data %0h want addr %0d data %0h",
                     bus.mem_addr, bus.mem_wdata, e.addr, e.data);
          end
          fd_q = e.last;
        end
      end
      if (bus.rd_valid === 1'b1) begin
        total++;
        if (rd_exp.size() == 0) begin
          bad++;
          $display("FAIL unexpected_rd_valid: data got %0h want no rd_valid", bus.rd_data);
        end else if (bus.rd_data !== rd_exp[0]) begin
          bad++;
          $display("FAIL rd_data: got %0h want %0h", bus.rd_data, rd_exp[0]);
          void'(rd_exp.pop_front());
        end else begin
          void'(rd_exp.pop_front());
        end
      end
      if (bus.wr_valid && bus.wr_ready) begin
        if (bus.wr_x < 10'd640 && bus.wr_y < 9'd480) begin
          e.addr = 19'(int'(bus.wr_x) + 640 * int'(bus.wr_y));
          e.data = bus.wr_data;
          e.last = (bus.wr_x == 10'd639) && (bus.wr_y == 9'd479);
          wr_exp.push_back(e);
        end else begin
          coord_exp = 1'b1;
        end
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_write(input int x, input int y, input int d);
    int n;
    n = 0;
    tick();
    bus.wr_valid = 1'b1;
    bus.wr_x     = 10'(x);
    bus.wr_y     = 9'(y);
    bus.wr_data  = 4'(d);
    @(negedge CLK);
    while (!bus.wr_ready && n < 20) begin
      tick();
      @(negedge CLK);
      n++;
    end
    if (n >= 20) begin
      bad++;
      $display("FAIL write_handshake_timeout: got no ready want ready within 20 cycles");
    end
    tick();
    bus.wr_valid = 1'b0;
  endtask

  task automatic do_read(input int x, input int y, input logic [3:0] exp_d);
    tick();
    bus.rd_req = 1'b1;
    bus.rd_x   = 10'(x);
    bus.rd_y   = 10'(y);
    rd_exp.push_back(exp_d);
    @(negedge CLK);
    tick();
    bus.rd_req = 1'b0;
  endtask

  task automatic test_reset();
    int we_cnt;
    int rv_cnt;
    we_cnt = 0;
    rv_cnt = 0;
    RESET = 1'b1;
    repeat (3) tick();
    RESET = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      if (bus.mem_we === 1'b1) we_cnt++;
      if (bus.rd_valid === 1'b1) rv_cnt++;
    end
    total++;
    if (we_cnt != 0) begin bad++; $display("FAIL idle_mem_we: got %0d want 0", we_cnt); end
    total++;
    if (rv_cnt != 0) begin bad++; $display("FAIL idle_rd_valid: got %0d want 0", rv_cnt); end
    total++;
    if (bus.wr_ready !== 1'b1) begin
      bad++;
      $display("FAIL idle_wr_ready: got %0b want 1", bus.wr_ready);
    end
    total++;
    if (bus.fifo_level !== 3'd0) begin
      bad++;
      $display("FAIL idle_level: got %0d want 0", bus.fifo_level);
    end
    total++;
    if (bus.rd_data !== 4'd0) begin
      bad++;
      $display("FAIL idle_rd_data: got %0h want 0", bus.rd_data);
    end
  endtask

  task automatic test_write_read();
    bit found;
    found = 1'b0;
    do_write(5, 2, 4'hA);
    for (int i = 0; i < 8 && !found; i++) begin
      @(negedge CLK);
      if (ph != 2'd0) begin
        found = 1'b1;
        total++;
        if (bus.mem_we !== 1'b1 || bus.mem_addr !== 19'd1285) begin
          bad++;
          $display("FAIL first_write_slot: got we=%0b addr=%0d want we=1 addr=1285",
                   bus.mem_we, bus.mem_addr);
        end
      end
    end
    if (!found) begin bad++; $display("FAIL first_write_slot: got none want a write slot"); end
    do_read(5, 2, 4'hA);
    found = 1'b0;
    for (int i = 0; i < 8 && !found; i++) begin
      @(negedge CLK);
      if (ph == 2'd0) found = 1'b1;
    end
    total++;
    if (!found || bus.mem_addr !== 19'd1285 || bus.mem_we !== 1'b0) begin
      bad++;
      $display("FAIL read_issue: got addr=%0d we=%0b want addr=1285 we=0", bus.mem_addr,
               bus.mem_we);
    end
    for (int k = 0; k < RD_LAT; k++) begin
      @(negedge CLK);
      total++;
      if (bus.rd_valid !== 1'b0) begin
        bad++;
        $display("FAIL rd_valid_early: got %0b want 0", bus.rd_valid);
      end
    end
    @(negedge CLK);
    total++;
    if (bus.rd_valid !== 1'b1 || bus.rd_data !== 4'hA) begin
      bad++;
      $display("FAIL read_back: got valid=%0b data=%0h want valid=1 data=a", bus.rd_valid,
               bus.rd_data);
    end
  endtask

  task automatic test_backpressure();
    int idx;
    int cyc;
    int req_cnt;
    int iss_cnt;
    bit pend;
    bit saw_full;
    idx = 0; cyc = 0; req_cnt = 0; iss_cnt = 0; pend = 1'b0; saw_full = 1'b0;
    while (idx < 16 && cyc < 80) begin
      tick();
      cyc++;
      bus.wr_valid = 1'b1;
      bus.wr_x     = 10'(20 + idx);
      bus.wr_y     = 9'd3;
      bus.wr_data  = 4'(idx);
      bus.rd_req   = (ph == 2'd1);
      if (ph == 2'd1) begin
        bus.rd_x = 10'd5;
        bus.rd_y = 10'd2;
        rd_exp.push_back(4'hA);
        pend = 1'b1;
        req_cnt++;
      end
      @(negedge CLK);
      if (ph == 2'd0 && pend) begin
        pend = 1'b0;
        iss_cnt++;
        total++;
        if (bus.mem_addr !== 19'd1285 || bus.mem_we !== 1'b0) begin
          bad++;
          $display("FAIL bp_read_slot: got addr=%0d we=%0b want 1285/0", bus.mem_addr,
                   bus.mem_we);
        end
      end
      if (bus.wr_ready === 1'b0) saw_full = 1'b1;
      if (bus.wr_ready === 1'b1) idx++;
    end
    tick();
    bus.wr_valid = 1'b0;
    bus.rd_req   = 1'b0;
    for (int i = 0; i < 24; i++) begin
      @(negedge CLK);
      if (ph == 2'd0 && pend) begin
        pend = 1'b0;
        iss_cnt++;
        total++;
        if (bus.mem_addr !== 19'd1285 || bus.mem_we !== 1'b0) begin
          bad++;
          $display("FAIL bp_read_slot: got addr=%0d we=%0b want 1285/0", bus.mem_addr,
                   bus.mem_we);
        end
      end
    end
    total++;
    if (idx != 16) begin bad++; $display("FAIL bp_accepted: got %0d want 16", idx); end
    total++;
    if (!saw_full) begin bad++; $display("FAIL bp_full: got no backpressure want some"); end
    total++;
    if (iss_cnt != req_cnt) begin
      bad++;
      $display("FAIL bp_reads: got %0d issued want %0d", iss_cnt, req_cnt);
    end
    total++;
    if (wr_exp.size() != 0 || rd_exp.size() != 0) begin
      bad++;
      $display("FAIL bp_drain: got %0d writes %0d reads left want 0/0", wr_exp.size(),
               rd_exp.size());
    end
  endtask

  task automatic test_boundaries();
    int fd_cnt;
    bit seen;
    bit found;
    fd_cnt = 0; seen = 1'b0; found = 1'b0;
    do_write(0, 0, 4'hF);
    do_write(639, 479, 4'h5);
    for (int i = 0; i < 12; i++) begin
      @(negedge CLK);
      if (bus.frame_done === 1'b1) fd_cnt++;
      if (bus.mem_we === 1'b1 && bus.mem_addr === 19'd307199) seen = 1'b1;
    end
    total++;
    if (!seen) begin bad++; $display("FAIL last_pixel_addr: got none want 307199"); end
    total++;
    if (fd_cnt != 1) begin bad++; $display("FAIL frame_done_count: got %0d want 1", fd_cnt); end
    do_write(640, 0, 4'h3);
    @(negedge CLK);
    total++;
    if (bus.coord_err !== 1'b1 || bus.fifo_level !== 3'd0) begin
      bad++;
      $display("FAIL oob_write: got err=%0b level=%0d want err=1 level=0", bus.coord_err,
               bus.fifo_level);
    end
    do_read(0, 480, 4'h0);
    for (int i = 0; i < 8 && !found; i++) begin
      @(negedge CLK);
      if (ph == 2'd0) found = 1'b1;
    end
    total++;
    if (!found || bus.mem_addr !== 19'd0 || bus.mem_we !== 1'b0) begin
      bad++;
      $display("FAIL oob_read_issue: got addr=%0d we=%0b want 0/0", bus.mem_addr, bus.mem_we);
    end
    repeat (RD_LAT + 1) @(negedge CLK);
    total++;
    if (bus.rd_valid !== 1'b1 || bus.rd_data !== 4'h0) begin
      bad++;
      $display("FAIL oob_read: got valid=%0b data=%0h want 1/0", bus.rd_valid, bus.rd_data);
    end
  endtask

  task automatic test_overwrite();
    int n;
    int rv_cnt;
    bit found;
    n = 0; rv_cnt = 0; found = 1'b0;
    do_write(1, 1, 4'h3);
    do_write(2, 2, 4'h7);
    repeat (8) @(negedge CLK);
    tick();
    while (ph != 2'd1 && n < 8) begin
      tick();
      n++;
    end
    bus.rd_req = 1'b1;
    bus.rd_x   = 10'd1;
    bus.rd_y   = 10'd1;
    tick();
    bus.rd_x   = 10'd2;
    bus.rd_y   = 10'd2;
    rd_exp.push_back(4'h7);
    tick();
    bus.rd_req = 1'b0;
    for (int i = 0; i < 8 && !found; i++) begin
      @(negedge CLK);
      if (ph == 2'd0) found = 1'b1;
    end
    total++;
    if (!found || bus.mem_addr !== 19'd1282) begin
      bad++;
      $display("FAIL overwrite_addr: got %0d want 1282", bus.mem_addr);
    end
    for (int i = 0; i < 8; i++) begin
      @(negedge CLK);
      if (bus.rd_valid === 1'b1) rv_cnt++;
    end
    total++;
    if (rv_cnt != 1) begin bad++; $display("FAIL overwrite_reads: got %0d want 1", rv_cnt); end
  endtask

  task automatic test_reset_mid();
    int idx;
    int cyc;
    int we_cnt;
    int rv_cnt;
    bit pend;
    bit armed;
    idx = 0; cyc = 0; we_cnt = 0; rv_cnt = 0; pend = 1'b0; armed = 1'b0;
    while (!armed && cyc < 80) begin
      tick();
      cyc++;
      bus.wr_valid = 1'b1;
      bus.wr_x     = 10'(100 + idx);
      bus.wr_y     = 9'd20;
      bus.wr_data  = 4'(idx);
      bus.rd_req   = (ph == 2'd1);
      if (ph == 2'd1) begin
        bus.rd_x = 10'd5;
        bus.rd_y = 10'd2;
        rd_exp.push_back(4'hA);
        pend = 1'b1;
      end
      @(negedge CLK);
      if (ph == 2'd0 && pend && bus.fifo_level >= 3'd2 && bus.wr_ready === 1'b1) armed = 1'b1;
      else if (ph == 2'd0) pend = 1'b0;
      if (bus.wr_ready === 1'b1) idx++;
    end
    total++;
    if (!armed) begin bad++; $display("FAIL mid_setup: got no queue want 3 queued"); end
    tick();
    RESET        = 1'b1;
    bus.wr_valid = 1'b0;
    bus.rd_req   = 1'b0;
    @(negedge CLK);
    total++;
    if (bus.fifo_level < 3'd3) begin
      bad++;
      $display("FAIL mid_queued: got %0d want >=3", bus.fifo_level);
    end
    tick();
    RESET = 1'b0;
    @(negedge CLK);
    total++;
    if (bus.fifo_level !== 3'd0 || bus.coord_err !== 1'b0 || bus.rd_data !== 4'd0) begin
      bad++;
      $display("FAIL mid_reset_state: got level=%0d err=%0b data=%0h want 0/0/0",
               bus.fifo_level, bus.coord_err, bus.rd_data);
    end
    for (int i = 0; i < 16; i++) begin
      if (bus.mem_we === 1'b1) we_cnt++;
      if (bus.rd_valid === 1'b1) rv_cnt++;
      @(negedge CLK);
    end
    total++;
    if (we_cnt != 0 || rv_cnt != 0) begin
      bad++;
      $display("FAIL mid_after: got writes=%0d rd_valid=%0d want 0/0", we_cnt, rv_cnt);
    end
  endtask

  initial begin
    total        = 0;
    bad          = 0;
    coord_exp    = 1'b0;
    fd_q         = 1'b0;
    RESET        = 1'b1;
    bus.rd_req   = 1'b0;
    bus.rd_x     = '0;
    bus.rd_y     = '0;
    bus.wr_valid = 1'b0;
    bus.wr_x     = '0;
    bus.wr_y     = '0;
    bus.wr_data  = '0;
    test_reset();
    test_write_read();
    test_backpressure();
    test_boundaries();
    test_overwrite();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
